// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and helpers shared by the fetch front end.
//   INST_W      - instruction width in bits
//   FETCH_BYTES - bytes returned per instruction-memory read (PC step per issue)
//   NOP_INST    - value driven on an instruction slot whose valid bit is low
//   bswap32     - byte reversal of one instruction word (only used when
//                 FETCH_BSWAP_EN is defined, for little-endian hex images)
package fetch_pkg;

   localparam int INST_W      = 32;
   localparam int FETCH_BYTES = 8;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   function automatic logic [INST_W-1:0] bswap32(input logic [INST_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundle of every non-clock/reset signal of fetch_stage.
//   master modport - the fetch stage side
//   slave modport  - instruction memory + decoder + redirect source side
// Signals:
//   halt_i, redirect_i, redirect_pc_i   control into fetch
//   imem_re_o, imem_addr_o, imem_data_i instruction-memory read port (data one cycle after re)
//   dec_valid_o, dec_inst0/1_o, dec_pc0/1_o, dec_pop_i  two-slot decoder port
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int IMEM_AW = 10
);
   logic                    halt_i;
   logic                    redirect_i;
   logic [IMEM_AW-1:0]      redirect_pc_i;
   logic                    imem_re_o;
   logic [IMEM_AW-1:0]      imem_addr_o;
   logic [2*INST_W-1:0]     imem_data_i;
   logic [1:0]              dec_valid_o;
   logic [INST_W-1:0]       dec_inst0_o;
   logic [IMEM_AW-1:0]      dec_pc0_o;
   logic [INST_W-1:0]       dec_inst1_o;
   logic [IMEM_AW-1:0]      dec_pc1_o;
   logic [1:0]              dec_pop_i;

   modport master (
      input  halt_i, redirect_i, redirect_pc_i, imem_data_i, dec_pop_i,
      output imem_re_o, imem_addr_o, dec_valid_o,
             dec_inst0_o, dec_pc0_o, dec_inst1_o, dec_pc1_o
   );

   modport slave (
      output halt_i, redirect_i, redirect_pc_i, imem_data_i, dec_pop_i,
      input  imem_re_o, imem_addr_o, dec_valid_o,
             dec_inst0_o, dec_pc0_o, dec_inst1_o, dec_pc1_o
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer of QDEPTH {inst,pc} entries.
//   clock_i, reset_i  clock, synchronous active-high reset
//   flush             synchronous empty (wins over push/pop)
//   push              write both write ports (always 2 entries, [0] oldest)
//   pop               entries consumed this cycle (0..2)
//   wr_inst, wr_pc    two write ports
//   rd_inst, rd_pc    two read ports, [0] = head (oldest)
//   count             current occupancy (0..QDEPTH)
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int QDEPTH = 4,
   parameter  int AW     = 10,
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = PW + 1
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   flush,
   input  logic                   push,
   input  logic [1:0]             pop,
   input  logic [1:0][INST_W-1:0] wr_inst,
   input  logic [1:0][AW-1:0]     wr_pc,
   output logic [1:0][INST_W-1:0] rd_inst,
   output logic [1:0][AW-1:0]     rd_pc,
   output logic [CW-1:0]          count
);

   logic [INST_W-1:0] inst_mem [QDEPTH];
   logic [AW-1:0]     pc_mem   [QDEPTH];
   logic [PW-1:0]     head, tail;

   // QDEPTH is a power of two, so pointer overflow is the wrap.
   always_ff @(posedge clock_i) begin
      if (reset_i || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(2);
         head  <= head + PW'(pop);
         count <= count + (push ? CW'(2) : CW'(0)) - CW'(pop);
      end
   end

   // Storage is not reset; count alone decides what is valid.
   always_ff @(posedge clock_i) begin
      if (push && !flush && !reset_i) begin
         inst_mem[tail]          <= wr_inst[0];
         pc_mem[tail]            <= wr_pc[0];
         inst_mem[tail + PW'(1)] <= wr_inst[1];
         pc_mem[tail + PW'(1)]   <= wr_pc[1];
      end
   end

   for (genvar s = 0; s < 2; s++) begin : g_rd
      assign rd_inst[s] = inst_mem[head + PW'(s)];
      assign rd_pc[s]   = pc_mem[head + PW'(s)];
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: front-end fetch unit. Issues one 8-byte instruction-memory read
// per cycle, splits each returned doubleword into two tagged instructions and
// queues them for a dual-issue decoder that drains 0..2 per cycle.
//   clock_i  single clock, posedge
//   reset_i  synchronous active-high reset
//   bus      fetch_if.master: halt/redirect control, imem read port, decoder port
// Parameters: IMEM_AW (byte-address width, PC wraps), RESET_PC, QDEPTH (pow2, >=4).
// Build option FETCH_BSWAP_EN: byte-reverse each instruction before it is queued.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int IMEM_AW  = 10,
   parameter int RESET_PC = 0,
   parameter int QDEPTH   = 4
) (
   input  logic     clock_i,
   input  logic     reset_i,
   fetch_if.master  bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [IMEM_AW-1:0]      pc_q;        // address of the next read to issue
   logic                    inflight_q;  // a read issued last cycle returns now
   logic                    resp_ok;
   logic                    issue;
   logic [IMEM_AW-1:0]      fetch_addr;
   logic [CW-1:0]           count;
   logic [CW:0]             count_nx;    // one spare bit: count_nx+2 must not overflow
   logic [1:0]              valid;
   logic [INST_W-1:0]       hi_w, lo_w;
   logic [1:0][INST_W-1:0]  wr_inst, rd_inst;
   logic [1:0][IMEM_AW-1:0] wr_pc, rd_pc;

   assign resp_ok    = inflight_q & ~bus.redirect_i;
   assign fetch_addr = bus.redirect_i ? bus.redirect_pc_i : pc_q;

   // Issue only if the queue is guaranteed room for the returning pair
   // after this cycle's pops and pushes.
   always_comb begin
      count_nx = '0;
      if (!bus.redirect_i)
         count_nx = {1'b0, count} - (CW+1)'(bus.dec_pop_i)
                  + (resp_ok ? (CW+1)'(2) : (CW+1)'(0));
      issue = ~reset_i & ~bus.halt_i & ((count_nx + (CW+1)'(2)) <= (CW+1)'(QDEPTH));
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         pc_q       <= IMEM_AW'(RESET_PC);
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue)
            pc_q <= fetch_addr + IMEM_AW'(FETCH_BYTES);
         else if (bus.redirect_i)
            pc_q <= bus.redirect_pc_i;   // halted redirect: remember the target
      end
   end

   // pc_q already points one doubleword past the read now returning.
`ifdef FETCH_BSWAP_EN
   assign hi_w = bswap32(bus.imem_data_i[63:32]);
   assign lo_w = bswap32(bus.imem_data_i[31:0]);
`else
   assign hi_w = bus.imem_data_i[63:32];
   assign lo_w = bus.imem_data_i[31:0];
`endif
   assign wr_inst[0] = hi_w;
   assign wr_inst[1] = lo_w;
   assign wr_pc[0]   = pc_q - IMEM_AW'(8);
   assign wr_pc[1]   = pc_q - IMEM_AW'(4);

   fetch_queue #(.QDEPTH(QDEPTH), .AW(IMEM_AW)) u_queue (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush   (bus.redirect_i),
      .push    (resp_ok),
      .pop     (bus.dec_pop_i),
      .wr_inst (wr_inst),
      .wr_pc   (wr_pc),
      .rd_inst (rd_inst),
      .rd_pc   (rd_pc),
      .count   (count)
   );

   always_comb begin
      valid = 2'b00;
      if (!reset_i) begin
         if (count >= CW'(2))     valid = 2'b11;
         else if (count != '0)    valid = 2'b01;
      end
   end

   assign bus.imem_re_o   = issue;
   assign bus.imem_addr_o = fetch_addr;
   assign bus.dec_valid_o = valid;
   assign bus.dec_inst0_o = valid[0] ? rd_inst[0] : NOP_INST;
   assign bus.dec_pc0_o   = rd_pc[0];
   assign bus.dec_inst1_o = valid[1] ? rd_inst[1] : NOP_INST;
   assign bus.dec_pc1_o   = rd_pc[1];

`ifndef SYNTHESIS
   logic [1:0] pop_max;
   assign pop_max = valid[1] ? 2'd2 : {1'b0, valid[0]};

   // Consumer may not pop more than is shown (pop is ignored during redirect).
   a_pop_legal: assert property (@(posedge clock_i) disable iff (reset_i)
      !bus.redirect_i |-> (bus.dec_pop_i <= pop_max));
`endif

endmodule
